// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace FIFO: packet layout, control states and widths.
package rvfi_trace_pkg;

  localparam int XLEN    = 64;
  localparam int ORDER_W = 64;
  localparam int MASK_W  = XLEN / 8;

  // One retired instruction as seen on the RVFI port, fields in port order.
  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic               trap;
    logic               halt;
    logic               intr;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic [XLEN-1:0]    mem_addr;
    logic [XLEN-1:0]    mem_wdata;
    logic [MASK_W-1:0]  mem_rmask;
    logic [MASK_W-1:0]  mem_wmask;
  } rvfi_pkt_t;

  // Control FSM: HALTED is left only through reset or clr.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } trace_state_e;

endpackage

// File: rtl/rvfi_trace_fifo_if.sv
// RVFI retirement port plus the valid/ready packet stream towards the consumer.
interface rvfi_trace_fifo_if;
  import rvfi_trace_pkg::*;

  logic               rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [31:0]        rvfi_insn;
  logic               rvfi_trap;
  logic               rvfi_halt;
  logic               rvfi_intr;
  logic [XLEN-1:0]    rvfi_pc_rdata;
  logic [XLEN-1:0]    rvfi_pc_wdata;
  logic [4:0]         rvfi_rd_addr;
  logic [XLEN-1:0]    rvfi_rd_wdata;
  logic [XLEN-1:0]    rvfi_mem_addr;
  logic [XLEN-1:0]    rvfi_mem_wdata;
  logic [MASK_W-1:0]  rvfi_mem_rmask;
  logic [MASK_W-1:0]  rvfi_mem_wmask;

  logic               out_valid;
  logic               out_ready;
  rvfi_pkt_t          out_pkt;

  // Environment side: the core retiring packets and the consumer taking them.
  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
           out_ready,
    input  out_valid, out_pkt
  );

  // FIFO side.
  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
           out_ready,
    output out_valid, out_pkt
  );

endinterface

// File: rtl/rvfi_trace_mem.sv
// DEPTH-entry packet storage: one synchronous write port, asynchronous read at the read pointer.
module rvfi_trace_mem
  import rvfi_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  rvfi_pkt_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output rvfi_pkt_t        rdata
);

  rvfi_pkt_t mem [DEPTH];

  // Capture the incoming packet into the slot addressed by the write pointer.
  // NOTE: no reset on the array; level gates validity, so stale contents are never observed.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rvfi_trace_fifo.sv
// Buffers RVFI retirements for a valid/ready consumer, flags drops when full,
// and checks that rvfi_order is contiguous and that nothing retires after a halt.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clr,
  rvfi_trace_fifo_if.slave   bus,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic               order_err,
  output logic [ORDER_W-1:0] err_order
);

  trace_state_e       state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ORDER_W-1:0] expected;
  rvfi_pkt_t          in_pkt;
  logic               full;
  logic               push;
  logic               pop;

  assign in_pkt = '{
    order:     bus.rvfi_order,
    insn:      bus.rvfi_insn,
    trap:      bus.rvfi_trap,
    halt:      bus.rvfi_halt,
    intr:      bus.rvfi_intr,
    pc_rdata:  bus.rvfi_pc_rdata,
    pc_wdata:  bus.rvfi_pc_wdata,
    rd_addr:   bus.rvfi_rd_addr,
    rd_wdata:  bus.rvfi_rd_wdata,
    mem_addr:  bus.rvfi_mem_addr,
    mem_wdata: bus.rvfi_mem_wdata,
    mem_rmask: bus.rvfi_mem_rmask,
    mem_wmask: bus.rvfi_mem_wmask
  };

  // Occupancy is the single source of truth for full/empty.
  assign full          = (level == LVL_W'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push          = bus.rvfi_valid && (state == RUN) && (!full || pop);

  rvfi_trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_pkt),
    .raddr (rd_ptr),
    .rdata (bus.out_pkt)
  );

  // Pointer and occupancy bookkeeping; clr wins over push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // Control FSM with order check and sticky error/overflow flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      expected  <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      err_order <= '0;
    end else if (clr) begin
      state     <= RUN;
      expected  <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      err_order <= '0;
    end else if (bus.rvfi_valid) begin
      case (state)
        RUN: begin
          if (bus.rvfi_order != expected) begin
            order_err <= 1'b1;
            if (!order_err) err_order <= bus.rvfi_order;
          end
          // Resynchronise on every packet, dropped ones included.
          expected <= bus.rvfi_order + ORDER_W'(1);
          if (!push)              overflow <= 1'b1;
          else if (bus.rvfi_halt) state    <= HALTED;
        end
        HALTED: begin
          order_err <= 1'b1;
          if (!order_err) err_order <= bus.rvfi_order;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
